uart_tx_gen: RTL

UART_TX_GEN -- requirements
Module: uart_tx_gen

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmitter: FSM states, parity and stop-bit
// modes, the per-frame configuration snapshot and the parity-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  typedef enum logic [1:0] {
    STOP_1     = 2'd0,
    STOP_1P5   = 2'd1,
    STOP_2     = 2'd2,
    STOP_2_ALT = 2'd3
  } stop_e;

  typedef struct packed {
    logic [1:0] data_bits;
    parity_e    parity;
    stop_e      stop;
  } frame_cfg_t;

  // Reserved codes 5..7 behave as "no parity".
  function automatic parity_e decode_parity(input logic [2:0] p);
    return (p > 3'd4) ? PAR_NONE : parity_e'(p);
  endfunction

  function automatic logic parity_bit(input parity_e p, input logic data_xor);
    logic b;
    case (p)
      PAR_EVEN: b = data_xor;
      PAR_ODD:  b = ~data_xor;
      PAR_MARK: b = 1'b1;
      default:  b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding queued TX characters; used by uart_tx_gen only when
// UART_TX_FIFO_EN is defined. Push when full and pop when empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: prescaled tick, 5..8 data bits, parity, 1/1.5/2 stop, line
// break. Define UART_TX_FIFO_EN for a FIFO_DEPTH queue, else a 1-entry holding register.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic [1:0]  data_bits,
  input  logic [2:0]  parity,
  input  logic [1:0]  stop_bits,
  input  logic        break_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [8:0]  level_o
);

  localparam logic [9:0] OS_LAST     = 10'(OVERSAMPLE - 1);
  localparam logic [9:0] STOP15_LAST = 10'((OVERSAMPLE * 3) / 2 - 1);
  localparam logic [9:0] STOP2_LAST  = 10'(2 * OVERSAMPLE - 1);

  logic       push, pop;
  logic       q_full, q_empty;
  logic [7:0] q_data;

  assign push    = valid_i & ~q_full;
  assign ready_o = ~q_full;

`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (pop),
    .data_o  (q_data),
    .full_o  (q_full),
    .empty_o (q_empty),
    .level_o (fifo_level)
  );

  assign level_o = 9'(fifo_level);
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  // Push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst)       hold_vld_q <= 1'b0;
    else if (push) hold_vld_q <= 1'b1;
    else if (pop)  hold_vld_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) hold_q <= data_i;
  end

  assign q_full  = hold_vld_q;
  assign q_empty = ~hold_vld_q;
  assign q_data  = hold_q;
  assign level_o = {8'd0, hold_vld_q};
`endif

  logic [15:0] presc_q;
  logic        tick;

  assign tick = (presc_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst)       presc_q <= '0;
    else if (tick) presc_q <= baud_div;
    else           presc_q <= presc_q - 16'd1;
  end

  state_e     state_q, state_d;
  frame_cfg_t cfg_q, cfg_d;
  logic [9:0] tcnt_q, tcnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic [2:0] bit_last;
  logic [9:0] stop_last;
  logic       bit_end;

  assign bit_last = {1'b0, cfg_q.data_bits} + 3'd4;
  assign bit_end  = (tcnt_q == OS_LAST);

  always_comb begin
    case (cfg_q.stop)
      STOP_1:   stop_last = OS_LAST;
      STOP_1P5: stop_last = STOP15_LAST;
      default:  stop_last = STOP2_LAST;
    endcase
  end

  // NOTE: every signal written here gets a default first, otherwise an untaken branch would infer a latch.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    tcnt_d    = tcnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (break_i) begin
            state_d = ST_BREAK;
            tcnt_d  = '0;
            tx_d    = 1'b0;
          end else if (!q_empty) begin
            pop       = 1'b1;
            cfg_d     = '{data_bits: data_bits, parity: decode_parity(parity),
                          stop: stop_e'(stop_bits)};
            shift_d   = q_data;
            par_d     = 1'b0;
            bit_idx_d = '0;
            tcnt_d    = '0;
            state_d   = ST_START;
            tx_d      = 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_d = ST_DATA;
            tcnt_d  = '0;
            tx_d    = shift_q[0];
          end else begin
            tcnt_d = tcnt_q + 10'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            tcnt_d  = '0;
            par_d   = par_q ^ shift_q[0];
            shift_d = shift_q >> 1;
            if (bit_idx_q == bit_last) begin
              if (cfg_q.parity != PAR_NONE) begin
                state_d = ST_PARITY;
                tx_d    = parity_bit(cfg_q.parity, par_q ^ shift_q[0]);
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              tx_d      = shift_q[1];
            end
          end else begin
            tcnt_d = tcnt_q + 10'd1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_d = ST_STOP;
            tcnt_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 10'd1;
          end
        end
        ST_STOP: begin
          if (tcnt_q == stop_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 10'd1;
          end
        end
        ST_BREAK: begin
          // Line low while requested; then a full bit time of idle-high before leaving.
          if (break_i) begin
            tcnt_d = '0;
            tx_d   = 1'b0;
          end else begin
            tx_d = 1'b1;
            if (bit_end) state_d = ST_IDLE;
            else         tcnt_d  = tcnt_q + 10'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_q     <= '{data_bits: 2'd3, parity: PAR_NONE, stop: STOP_1};
      tcnt_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      tcnt_q    <= tcnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign tx_o   = tx_q;
  assign done_o = done_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule
